imem_fetch_ctrl: RTL and testbench

- Fetch sequencer that drives the address of the 256-byte asynchronous-read instruction memory.
- Boots from the reset vector and assembles 1- or 2-byte instructions.
- Hands each instruction to decode over a valid/ready handshake.
- Services branch redirects and a single vectored interrupt. Sits between instruction memory and the decode/control unit.

---
 rtl/imem_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: boots from the reset vector and assembles 1/2-byte
// instructions from an async-read byte memory. Also handles redirects and one vectored interrupt.
module imem_fetch_ctrl #(
  parameter logic [7:0] RST_VEC_ADDR = 8'h00,
  parameter logic [7:0] INT_VEC_ADDR = 8'h01,
  parameter logic [3:0] IMM_OPCODE   = 4'hC
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       ir_valid,
  input  logic       ir_ready,
  output logic [7:0] ir_opcode,
  output logic [7:0] ir_imm,
  output logic       ir_has_imm,
  output logic [7:0] ir_pc,
  input  logic       redir_valid,
  input  logic [7:0] redir_addr,
  input  logic       intr,
  input  logic       int_en,
  output logic       int_ack,
  output logic [7:0] ret_pc
);

  typedef enum logic [2:0] {
    VEC_RST,
    FETCH_OP,
    FETCH_IMM,
    HOLD,
    VEC_INT
  } state_t;

  state_t     state_reg;
  logic [7:0] pc_reg;
  logic       int_pend_reg;

  always_comb begin
    case (state_reg)
      VEC_RST: imem_addr = RST_VEC_ADDR;
      VEC_INT: imem_addr = INT_VEC_ADDR;
      default: imem_addr = pc_reg;
    endcase
  end

  // A redirect arriving in the vector cycle suppresses the acknowledge; the
  // interrupt stays pending and is taken at the next instruction boundary.
  assign int_ack = (state_reg == VEC_INT) && !redir_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= VEC_RST;
      pc_reg       <= 8'h00;
      int_pend_reg <= 1'b0;
      ir_valid     <= 1'b0;
      ir_opcode    <= 8'h00;
      ir_imm       <= 8'h00;
      ir_has_imm   <= 1'b0;
      ir_pc        <= 8'h00;
      ret_pc       <= 8'h00;
    end else begin
      if (intr && int_en && state_reg != VEC_RST && state_reg != VEC_INT)
        int_pend_reg <= 1'b1;

      if (state_reg != VEC_RST && redir_valid) begin
        pc_reg     <= redir_addr;
        ir_valid   <= 1'b0;
        ir_has_imm <= 1'b0;
        state_reg  <= FETCH_OP;
      end else begin
        case (state_reg)
          VEC_RST: begin
            pc_reg    <= imem_data;
            state_reg <= FETCH_OP;
          end
          FETCH_OP: begin
            if (int_pend_reg) begin
              ret_pc    <= pc_reg;
              state_reg <= VEC_INT;
            end else begin
              ir_opcode <= imem_data;
              ir_pc     <= pc_reg;
              pc_reg    <= pc_reg + 8'd1;
              if (imem_data[7:4] == IMM_OPCODE) begin
                ir_has_imm <= 1'b1;
                state_reg  <= FETCH_IMM;
              end else begin
                ir_imm     <= 8'h00;
                ir_has_imm <= 1'b0;
                ir_valid   <= 1'b1;
                state_reg  <= HOLD;
              end
            end
          end
          FETCH_IMM: begin
            ir_imm    <= imem_data;
            pc_reg    <= pc_reg + 8'd1;
            ir_valid  <= 1'b1;
            state_reg <= HOLD;
          end
          HOLD: begin
            if (ir_ready) begin
              ir_valid  <= 1'b0;
              state_reg <= FETCH_OP;
            end
          end
          VEC_INT: begin
            pc_reg       <= imem_data;
            int_pend_reg <= 1'b0;
            state_reg    <= FETCH_OP;
          end
          default: state_reg <= VEC_RST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a transaction-level model predicts each
// presented instruction from the bench-owned memory; directed checks pin timing.
module tb_imem_fetch_ctrl;

  localparam logic [7:0] RST_VEC_ADDR = 8'h00;
  localparam logic [7:0] INT_VEC_ADDR = 8'h01;
  localparam logic [3:0] IMM_OPCODE   = 4'hC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       ir_valid;
  logic       ir_ready = 1'b0;
  logic [7:0] ir_opcode;
  logic [7:0] ir_imm;
  logic       ir_has_imm;
  logic [7:0] ir_pc;
  logic       redir_valid = 1'b0;
  logic [7:0] redir_addr = 8'h00;
  logic       intr = 1'b0;
  logic       int_en = 1'b0;
  logic       int_ack;
  logic [7:0] ret_pc;

  logic [7:0] mem [256];
  assign imem_data = mem[imem_addr];

  int total = 0;
  int bad   = 0;

  imem_fetch_ctrl #(
    .RST_VEC_ADDR(RST_VEC_ADDR),
    .INT_VEC_ADDR(INT_VEC_ADDR),
    .IMM_OPCODE  (IMM_OPCODE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir_opcode  (ir_opcode),
    .ir_imm     (ir_imm),
    .ir_has_imm (ir_has_imm),
    .ir_pc      (ir_pc),
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .intr       (intr),
    .int_en     (int_en),
    .int_ack    (int_ack),
    .ret_pc     (ret_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  // Model: the PC of the next instruction decode should see.
  logic [7:0] model_pc = 8'h00;
  logic       boot = 1'b1;
  logic [7:0] m_op;
  logic [7:0] m_nxt;
  logic       m_has;
  int         ack_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      boot      = 1'b1;
      ack_count = 0;
    end else if (boot) begin
      model_pc = mem[RST_VEC_ADDR];
      boot     = 1'b0;
    end else begin
      m_op  = mem[model_pc];
      m_nxt = model_pc + 8'd1;
      m_has = (m_op[7:4] == IMM_OPCODE);
      if (ir_valid) begin
        chk("mdl_opcode", ir_opcode, m_op);
        chk("mdl_pc", ir_pc, model_pc);
        chk("mdl_has_imm", 8'(ir_has_imm), 8'(m_has));
        chk("mdl_imm", ir_imm, m_has ? mem[m_nxt] : 8'h00);
        if (ir_ready)
          $display("xfer pc=%02h op=%02h imm=%02h has_imm=%0d redir=%0d",
                   ir_pc, ir_opcode, ir_imm, ir_has_imm, redir_valid);
      end
      if (int_ack) begin
        ack_count++;
        chk("mdl_ack_vs_redir", 8'(redir_valid), 8'h00);
        chk("mdl_ret_pc", ret_pc, model_pc);
        $display("int_ack ret_pc=%02h", ret_pc);
        model_pc = mem[INT_VEC_ADDR];
      end
      if (redir_valid)
        model_pc = redir_addr;
      else if (ir_valid && ir_ready)
        model_pc = model_pc + (m_has ? 8'd2 : 8'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    rst         = 1'b1;
    ir_ready    = 1'b0;
    redir_valid = 1'b0;
    intr        = 1'b0;
    int_en      = 1'b0;
    step();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // Checks the reset state, then releases rst; the DUT is then in its vector cycle.
  task automatic end_reset();
    step();
    chk("rst_valid", 8'(ir_valid), 8'h00);
    chk("rst_opcode", ir_opcode, 8'h00);
    chk("rst_imm", ir_imm, 8'h00);
    chk("rst_has_imm", 8'(ir_has_imm), 8'h00);
    chk("rst_ir_pc", ir_pc, 8'h00);
    chk("rst_int_ack", 8'(int_ack), 8'h00);
    chk("rst_ret_pc", ret_pc, 8'h00);
    chk("rst_addr", imem_addr, RST_VEC_ADDR);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (ir_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
    chk("valid_timeout", 8'(ir_valid), 8'h01);
  endtask

  task automatic accept();
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
  endtask

  int n;
  logic [7:0] saved_addr;

  initial begin
    // Boot
    start_reset();
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'h00;
    end_reset();
    chk("boot_addr0", imem_addr, 8'h00);
    step();
    chk("boot_fetch_addr", imem_addr, 8'h10);
    wait_valid(8, n);
    chk("boot_latency", 8'(n), 8'd1);
    chk("boot_opcode", ir_opcode, 8'h00);
    chk("boot_ir_pc", ir_pc, 8'h10);
    chk("boot_has_imm", 8'(ir_has_imm), 8'h00);

    // Two-byte fetch, then stall
    start_reset();
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'hC1;
    mem[8'h11] = 8'h05;
    mem[8'h12] = 8'h03;
    mem[8'h13] = 8'h04;
    end_reset();
    wait_valid(8, n);
    chk("imm_latency", 8'(n), 8'd3);
    chk("imm_opcode", ir_opcode, 8'hC1);
    chk("imm_imm", ir_imm, 8'h05);
    chk("imm_has_imm", 8'(ir_has_imm), 8'h01);
    chk("imm_ir_pc", ir_pc, 8'h10);
    accept();
    chk("imm_next_addr", imem_addr, 8'h12);
    wait_valid(8, n);
    chk("next_latency", 8'(n), 8'd1);
    chk("next_ir_pc", ir_pc, 8'h12);
    saved_addr = imem_addr;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", 8'(ir_valid), 8'h01);
      chk("stall_addr", imem_addr, saved_addr);
      chk("stall_opcode", ir_opcode, 8'h03);
    end
    accept();
    chk("resume_addr", imem_addr, 8'h13);
    wait_valid(8, n);
    chk("resume_ir_pc", ir_pc, 8'h13);

    // Redirect during the immediate fetch
    start_reset();
    mem[8'h00] = 8'h10;
    mem[8'h10] = 8'hC1;
    mem[8'h11] = 8'h05;
    mem[8'h40] = 8'h21;
    end_reset();
    step();
    chk("rdi_op_addr", imem_addr, 8'h10);
    step();
    chk("rdi_imm_addr", imem_addr, 8'h11);
    chk("rdi_no_valid", 8'(ir_valid), 8'h00);
    redir_valid = 1'b1;
    redir_addr  = 8'h40;
    step();
    redir_valid = 1'b0;
    chk("rdi_discard", 8'(ir_valid), 8'h00);
    chk("rdi_target_addr", imem_addr, 8'h40);
    wait_valid(8, n);
    chk("rdi_ir_pc", ir_pc, 8'h40);
    chk("rdi_opcode", ir_opcode, 8'h21);

    // Interrupt taken after accepting the instruction at 0x20
    start_reset();
    mem[8'h00] = 8'h20;
    mem[8'h01] = 8'h80;
    mem[8'h20] = 8'h01;
    mem[8'h80] = 8'h02;
    mem[8'h50] = 8'h05;
    end_reset();
    wait_valid(8, n);
    chk("int_hold_ir_pc", ir_pc, 8'h20);
    intr   = 1'b1;
    int_en = 1'b1;
    step();
    intr   = 1'b0;
    int_en = 1'b0;
    chk("int_hold_pc", imem_addr, 8'h21);
    accept();
    chk("int_boundary_valid", 8'(ir_valid), 8'h00);
    step();
    chk("int_ack_pulse", 8'(int_ack), 8'h01);
    chk("int_ret_pc", ret_pc, 8'h21);
    chk("int_vec_addr", imem_addr, INT_VEC_ADDR);
    step();
    chk("int_ack_drop", 8'(int_ack), 8'h00);
    chk("int_handler_addr", imem_addr, 8'h80);
    wait_valid(8, n);
    chk("int_handler_ir_pc", ir_pc, 8'h80);
    chk("int_ack_count", 8'(ack_count), 8'd1);

    // Same, but a redirect lands in the vector cycle
    start_reset();
    mem[8'h00] = 8'h20;
    mem[8'h01] = 8'h80;
    mem[8'h20] = 8'h01;
    mem[8'h80] = 8'h02;
    mem[8'h50] = 8'h05;
    end_reset();
    wait_valid(8, n);
    intr   = 1'b1;
    int_en = 1'b1;
    step();
    intr   = 1'b0;
    int_en = 1'b0;
    accept();
    step();
    redir_valid = 1'b1;
    redir_addr  = 8'h50;
    #1;
    chk("vr_no_ack", 8'(int_ack), 8'h00);
    step();
    redir_valid = 1'b0;
    chk("vr_redir_addr", imem_addr, 8'h50);
    chk("vr_ack_count0", 8'(ack_count), 8'd0);
    step();
    chk("vr_late_ack", 8'(int_ack), 8'h01);
    chk("vr_ret_pc", ret_pc, 8'h50);
    step();
    wait_valid(8, n);
    chk("vr_handler_ir_pc", ir_pc, 8'h80);
    chk("vr_ack_count1", 8'(ack_count), 8'd1);

    // Wrap-around of a two-byte instruction at 0xFF
    start_reset();
    mem[8'h00] = 8'h33;
    mem[8'h33] = 8'h00;
    mem[8'hFF] = 8'hC2;
    mem[8'h01] = 8'h07;
    end_reset();
    wait_valid(8, n);
    chk("wrap_boot_ir_pc", ir_pc, 8'h33);
    redir_valid = 1'b1;
    redir_addr  = 8'hFF;
    step();
    redir_valid = 1'b0;
    chk("wrap_addr_ff", imem_addr, 8'hFF);
    wait_valid(8, n);
    chk("wrap_latency", 8'(n), 8'd2);
    chk("wrap_opcode", ir_opcode, 8'hC2);
    chk("wrap_imm", ir_imm, 8'h33);
    chk("wrap_ir_pc", ir_pc, 8'hFF);
    accept();
    chk("wrap_next_addr", imem_addr, 8'h01);
    wait_valid(8, n);
    chk("wrap_next_ir_pc", ir_pc, 8'h01);
    chk("wrap_next_opcode", ir_opcode, 8'h07);

    // Handshake and redirect in the same cycle
    ir_ready    = 1'b1;
    redir_valid = 1'b1;
    redir_addr  = 8'h40;
    step();
    ir_ready    = 1'b0;
    redir_valid = 1'b0;
    chk("hsr_valid", 8'(ir_valid), 8'h00);
    chk("hsr_addr", imem_addr, 8'h40);
    wait_valid(8, n);
    chk("hsr_ir_pc", ir_pc, 8'h40);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
